flappybird_soc_pio_pulse: RTL

FLAPPYBIRD_SOC_PIO_PULSE -- requirements
Module: flappybird_soc_pio_pulse

---
 rtl/flappybird_soc_pio_pulse.sv | 89 ++++++++
 1 files changed

// File: rtl/flappybird_soc_pio_pulse.sv
// Avalon-MM PIO with a timed pulse: selected output bits are inverted for
// PULSE_LEN cycles, then DONE is flagged and an optional level irq is raised.
module flappybird_soc_pio_pulse #(
  parameter int unsigned        WIDTH             = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE       = '0,
  parameter logic [15:0]        DEFAULT_PULSE_LEN = 16'd16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  typedef enum logic {IDLE, PULSE} state_t;

  state_t           state;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] pulse_mask;
  logic [15:0]      pulse_len;
  logic [15:0]      counter;
  logic             done;
  logic             irq_en;
  logic             we;
  logic             busy;
  logic             unused_wdata;

  assign we           = chipselect & ~write_n;
  assign busy         = (state == PULSE);
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      data       <= RESET_VALUE;
      pulse_mask <= '0;
      pulse_len  <= DEFAULT_PULSE_LEN;
      counter    <= '0;
      done       <= 1'b0;
      irq_en     <= 1'b0;
    end else begin
      if (we && address == 2'd0) data      <= writedata[WIDTH-1:0];
      if (we && address == 2'd2) pulse_len <= writedata[15:0];
      if (we && address == 2'd3) begin
        irq_en <= writedata[1];
        if (writedata[0]) done <= 1'b0;
      end
      // Completion is evaluated after the STATUS write so a coincident set wins.
      case (state)
        IDLE: begin
          if (we && address == 2'd1 && writedata[WIDTH-1:0] != '0 && pulse_len != 16'd0) begin
            pulse_mask <= writedata[WIDTH-1:0];
            counter    <= pulse_len;
            state      <= PULSE;
          end
        end
        PULSE: begin
          if (counter == 16'd1) begin
            pulse_mask <= '0;
            counter    <= '0;
            done       <= 1'b1;
            state      <= IDLE;
          end else begin
            counter <= counter - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = data;
      2'd1:    readdata[WIDTH-1:0] = pulse_mask;
      2'd2:    readdata[15:0]      = pulse_len;
      default: readdata[2:0]       = {busy, irq_en, done};
    endcase
  end

  assign out_port = data ^ pulse_mask;
  assign irq      = done & irq_en;

endmodule
